seqment_hex_decoder: RTL and testbench

//   Registered 4-bit hexadecimal to 7-segment decoder for one seven-segment digit.
//   One instance drives each HEX digit, e.g. a key-count high/low nibble or an ASCII/scan-code nibble.
//   The output is registered on clk, so the segments change only on clock edges.

---
 rtl/seqment_hex_decoder.sv | 58 +++++
 tb/tb_seqment_hex_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seqment_hex_decoder.sv
// Registered hex-to-seven-segment decoder for a single digit.
// Segment order is {g,f,e,d,c,b,a}; ACTIVE_LOW selects the drive polarity.
module seqment_hex_decoder #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       blank,
    input  logic [3:0] hex_in,
    output logic [6:0] seg_out
);

    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    logic [6:0] seg_low;
    logic [6:0] seg_dec;
    logic [6:0] seg_q = SEG_OFF;

    // Glyph table is kept in active-low form; unknown nibbles fall to dark.
    always_comb begin
        seg_low = 7'b1111111;
        case (hex_in)
            4'h0:    seg_low = 7'b1000000;
            4'h1:    seg_low = 7'b1111001;
            4'h2:    seg_low = 7'b0100100;
            4'h3:    seg_low = 7'b0110000;
            4'h4:    seg_low = 7'b0011001;
            4'h5:    seg_low = 7'b0010010;
            4'h6:    seg_low = 7'b0000010;
            4'h7:    seg_low = 7'b1111000;
            4'h8:    seg_low = 7'b0000000;
            4'h9:    seg_low = 7'b0010000;
            4'hA:    seg_low = 7'b0001000;
            4'hB:    seg_low = 7'b0000011;
            4'hC:    seg_low = 7'b1000110;
            4'hD:    seg_low = 7'b0100001;
            4'hE:    seg_low = 7'b0000110;
            4'hF:    seg_low = 7'b0001110;
            default: seg_low = 7'b1111111;
        endcase
    end

    assign seg_dec = ACTIVE_LOW ? seg_low : ~seg_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_OFF;
        end else if (blank) begin
            seg_q <= SEG_OFF;
        end else if (en) begin
            seg_q <= seg_dec;
        end
    end

    assign seg_out = seg_q;

endmodule

// File: tb/tb_seqment_hex_decoder.sv
// Directed bench for seqment_hex_decoder; one active-low and one active-high
// instance share the same stimulus.
module tb_seqment_hex_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       blank = 1'b0;
    logic [3:0] hex_in = 4'h0;
    logic [6:0] seg_lo;
    logic [6:0] seg_hi;

    int checks = 0;
    int failures = 0;

    logic [6:0] glyph [16];

    always #5 clk = ~clk;

    seqment_hex_decoder #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .blank(blank), .hex_in(hex_in), .seg_out(seg_lo)
    );

    seqment_hex_decoder #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .blank(blank), .hex_in(hex_in), .seg_out(seg_hi)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_powerup();
        checks++;
        if (seg_lo !== 7'b1111111) begin
            failures++;
            $display("FAIL powerup_lo got=%b exp=%b", seg_lo, 7'b1111111);
        end
        checks++;
        if (seg_hi !== 7'b0000000) begin
            failures++;
            $display("FAIL powerup_hi got=%b exp=%b", seg_hi, 7'b0000000);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; blank = 1'b0; hex_in = 4'h0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (seg_lo !== 7'b1111111) begin
                failures++;
                $display("FAIL reset_idle_lo cyc=%0d got=%b exp=%b", i, seg_lo, 7'b1111111);
            end
            checks++;
            if (seg_hi !== 7'b0000000) begin
                failures++;
                $display("FAIL reset_idle_hi cyc=%0d got=%b exp=%b", i, seg_hi, 7'b0000000);
            end
        end
    endtask

    task automatic test_sweep();
        en = 1'b1;
        for (int v = 0; v < 16; v++) begin
            hex_in = 4'(v);
            step();
            checks++;
            if (seg_lo !== glyph[v]) begin
                failures++;
                $display("FAIL sweep_lo hex=%h got=%b exp=%b", v, seg_lo, glyph[v]);
            end
            checks++;
            if (seg_hi !== ~glyph[v]) begin
                failures++;
                $display("FAIL sweep_hi hex=%h got=%b exp=%b", v, seg_hi, ~glyph[v]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_hold();
        en = 1'b1; hex_in = 4'h8;
        step();
        checks++;
        if (seg_lo !== 7'b0000000) begin
            failures++;
            $display("FAIL hold_load got=%b exp=%b", seg_lo, 7'b0000000);
        end
        en = 1'b0; hex_in = 4'h1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (seg_lo !== 7'b0000000) begin
                failures++;
                $display("FAIL hold_stay cyc=%0d got=%b exp=%b", i, seg_lo, 7'b0000000);
            end
        end
    endtask

    task automatic test_blank();
        blank = 1'b1; en = 1'b1; hex_in = 4'h5;
        step();
        checks++;
        if (seg_lo !== 7'b1111111) begin
            failures++;
            $display("FAIL blank_lo got=%b exp=%b", seg_lo, 7'b1111111);
        end
        checks++;
        if (seg_hi !== 7'b0000000) begin
            failures++;
            $display("FAIL blank_hi got=%b exp=%b", seg_hi, 7'b0000000);
        end
        blank = 1'b0; en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (seg_lo !== 7'b1111111) begin
                failures++;
                $display("FAIL blank_stay cyc=%0d got=%b exp=%b", i, seg_lo, 7'b1111111);
            end
        end
        en = 1'b1;
        step();
        checks++;
        if (seg_lo !== 7'b0010010) begin
            failures++;
            $display("FAIL blank_reload got=%b exp=%b", seg_lo, 7'b0010010);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; en = 1'b1; blank = 1'b0; hex_in = 4'h0;
        step();
        checks++;
        if (seg_lo !== 7'b1111111) begin
            failures++;
            $display("FAIL rst_wins got=%b exp=%b", seg_lo, 7'b1111111);
        end
        rst = 1'b0;
        step();
        checks++;
        if (seg_lo !== 7'b1000000) begin
            failures++;
            $display("FAIL rst_release got=%b exp=%b", seg_lo, 7'b1000000);
        end
        en = 1'b0;
    endtask

    task automatic test_active_high();
        en = 1'b1; hex_in = 4'h1;
        step();
        checks++;
        if (seg_hi !== 7'b0000110) begin
            failures++;
            $display("FAIL ah_one got=%b exp=%b", seg_hi, 7'b0000110);
        end
        en = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (seg_hi !== 7'b0000000) begin
            failures++;
            $display("FAIL ah_reset got=%b exp=%b", seg_hi, 7'b0000000);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [6];
        logic [6:0] exp_lo [6];
        seq = '{4'h3, 4'hB, 4'h7, 4'hE, 4'h2, 4'hD};
        exp_lo = '{7'b0110000, 7'b0000011, 7'b1111000, 7'b0000110, 7'b0100100, 7'b0100001};
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            hex_in = seq[i];
            step();
            checks++;
            if (seg_lo !== exp_lo[i]) begin
                failures++;
                $display("FAIL b2b hex=%h got=%b exp=%b", seq[i], seg_lo, exp_lo[i]);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        #1;
        test_powerup();
        step();
        test_reset();
        test_sweep();
        test_hold();
        test_blank();
        test_reset_priority();
        test_active_high();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
